// File: rtl/serial_add_ctrl_pkg.sv
// rtl/serial_add_ctrl_pkg.sv - shared state encodings and default width for the serial adder
// Contents:
//   DEFAULT_WIDTH : default operand/result width
//   state_e       : controller states ST_IDLE / ST_RUN / ST_DONE
package serial_add_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_add_ctrl_full_add_1bit.sv
// rtl/serial_add_ctrl_full_add_1bit.sv - 1-bit full adder built from two half-adder cells
// add_1bit ports:
//   a, b : input bits
//   s    : sum bit (a ^ b)
//   c    : carry bit (a & b)
// full_add_1bit ports:
//   a, b, cin : input bits
//   s         : sum bit
//   cout      : carry out
module add_1bit (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

module full_add_1bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic s0;
  logic c0;
  logic c1;

  add_1bit u_ha0 (
    .a (a),
    .b (b),
    .s (s0),
    .c (c0)
  );

  add_1bit u_ha1 (
    .a (s0),
    .b (cin),
    .s (s),
    .c (c1)
  );

  // Both half-adder carries can never be high together, so OR is the full carry.
  assign cout = c0 | c1;

endmodule

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial WIDTH-bit adder controller around one full-adder cell
// Ports:
//   clk    : clock, all state updates on rising edge
//   rst_n  : synchronous active-low reset
//   start  : request, accepted only in IDLE
//   a, b   : operands, sampled on the accepting edge
//   cin    : carry-in, sampled on the accepting edge
//   busy   : high in RUN and DONE
//   done   : one-cycle pulse when sum/cout/ovf are valid
//   sum    : result, held until the next operation completes or reset
//   cout   : unsigned carry out of MSB
//   ovf    : signed overflow
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CNT_W = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic             s_bit;
  logic             co_bit;
  logic [WIDTH-1:0] res_shift;

  full_add_1bit u_fa (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .cin  (carry_q),
    .s    (s_bit),
    .cout (co_bit)
  );

  // New sum bit enters at the MSB; after WIDTH shifts bit 0 lands at the LSB.
  assign res_shift = {s_bit, res_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_sr_d  = a;
          b_sr_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        a_sr_d  = a_sr_q >> 1;
        b_sr_d  = b_sr_q >> 1;
        res_d   = res_shift;
        carry_d = co_bit;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          // Visible result only changes here, so sum/cout never show partial values.
          sum_d   = res_shift;
          cout_d  = co_bit;
          ovf_d   = carry_q ^ co_bit;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign done = (state_q == ST_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule
